// File: rtl/gps_ca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gps_ca_pkg
//  Description : Shared constants, FSM encoding and the G2 phase-select tap
//                table for the multi-channel GPS L1 C/A code generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package gps_ca_pkg;

    localparam int         CA_LEN     = 1023;
    localparam int         SV_MAX     = 37;
    localparam logic [9:0] LAST_PHASE = 10'(CA_LEN - 1);

    // FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_GEN  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    // G2 output taps, numbered as LFSR stages 1..10
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } tap_t;

    function automatic logic sv_valid(input logic [5:0] sv);
        return (sv != 6'd0) && (sv <= 6'(SV_MAX));
    endfunction

    // Phase-select taps for SV 1..37; invalid SVs get a harmless in-range pair
    function automatic tap_t g2_taps(input logic [5:0] sv);
        tap_t t;
        case (sv)
            6'd1:  t = {4'd2, 4'd6};   6'd2:  t = {4'd3, 4'd7};
            6'd3:  t = {4'd4, 4'd8};   6'd4:  t = {4'd5, 4'd9};
            6'd5:  t = {4'd1, 4'd9};   6'd6:  t = {4'd2, 4'd10};
            6'd7:  t = {4'd1, 4'd8};   6'd8:  t = {4'd2, 4'd9};
            6'd9:  t = {4'd3, 4'd10};  6'd10: t = {4'd2, 4'd3};
            6'd11: t = {4'd3, 4'd4};   6'd12: t = {4'd5, 4'd6};
            6'd13: t = {4'd6, 4'd7};   6'd14: t = {4'd7, 4'd8};
            6'd15: t = {4'd8, 4'd9};   6'd16: t = {4'd9, 4'd10};
            6'd17: t = {4'd1, 4'd4};   6'd18: t = {4'd2, 4'd5};
            6'd19: t = {4'd3, 4'd6};   6'd20: t = {4'd4, 4'd7};
            6'd21: t = {4'd5, 4'd8};   6'd22: t = {4'd6, 4'd9};
            6'd23: t = {4'd1, 4'd3};   6'd24: t = {4'd4, 4'd6};
            6'd25: t = {4'd5, 4'd7};   6'd26: t = {4'd6, 4'd8};
            6'd27: t = {4'd7, 4'd9};   6'd28: t = {4'd8, 4'd10};
            6'd29: t = {4'd1, 4'd6};   6'd30: t = {4'd2, 4'd7};
            6'd31: t = {4'd3, 4'd8};   6'd32: t = {4'd4, 4'd9};
            6'd33: t = {4'd5, 4'd10};  6'd34: t = {4'd4, 4'd10};
            6'd35: t = {4'd1, 4'd7};   6'd36: t = {4'd2, 4'd8};
            6'd37: t = {4'd4, 4'd10};
            default: t = {4'd1, 4'd1};
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gps_ca_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : gps_ca_lfsr
//  Description : One G1/G2 LFSR pair producing one C/A chip per cycle for the
//                selected SV. Chip is forced low for an invalid SV.
//  Revision    : 1.0 - initial release
// ============================================================================
module gps_ca_lfsr
    import gps_ca_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    input  logic [5:0] sv,
    output logic       chip
);

    // bit i holds stage i+1, so stage 10 is bit 9
    logic [9:0] r_g1;
    logic [9:0] r_g2;
    tap_t       w_taps;

    // Chip from current state: G1 stage 10 xor the two selected G2 stages
    always_comb begin
        w_taps = g2_taps(sv);
        chip   = sv_valid(sv) &
                 (r_g1[9] ^ r_g2[w_taps.a - 4'd1] ^ r_g2[w_taps.b - 4'd1]);
    end

    // Shift toward stage 10 with feedback entering stage 1; load restores all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g1 <= 10'h3FF;
            r_g2 <= 10'h3FF;
        end else if (load) begin
            r_g1 <= 10'h3FF;
            r_g2 <= 10'h3FF;
        end else if (advance) begin
            r_g1 <= {r_g1[8:0], r_g1[2] ^ r_g1[9]};
            r_g2 <= {r_g2[8:0], r_g2[1] ^ r_g2[2] ^ r_g2[5] ^
                                r_g2[7] ^ r_g2[8] ^ r_g2[9]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/gps_ca_multi.sv
`default_nettype none
// ============================================================================
//  Module      : gps_ca_multi
//  Description : Multi-channel GPS L1 C/A generator. Per-channel LFSR pairs
//                share one code phase; CHIPS chips per channel are packed into
//                a word delivered over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module gps_ca_multi
    import gps_ca_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CHIPS   = 13,
    parameter int EPOCH_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      restart,
    input  logic [6*NUM_CH-1:0]       sv_num,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHIPS*NUM_CH-1:0]   ca_code,
    output logic [9:0]                chip_idx,
    output logic [EPOCH_W-1:0]        epoch_cnt,
    output logic [NUM_CH-1:0]         sv_err
);

    localparam int CNT_W = (CHIPS > 1) ? $clog2(CHIPS) : 1;

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_accept;
    logic                      w_gen;
    logic                      w_done;
    logic                      w_wrap;
    logic                      w_load;
    logic [6*NUM_CH-1:0]       r_sv;
    logic [NUM_CH-1:0]         r_sv_err;
    logic [NUM_CH-1:0]         w_sv_err_new;
    logic [9:0]                r_phase;
    logic [9:0]                r_word_phase;
    logic [EPOCH_W-1:0]        r_epoch;
    logic [CNT_W-1:0]          r_cnt;
    logic [NUM_CH-1:0]         w_chip;
    logic [CHIPS*NUM_CH-1:0]   r_word;
    logic [CHIPS*NUM_CH-1:0]   w_word_next;

    // A new request is taken only when no word is pending or the pending one leaves now
    assign w_accept = start && ((r_state == ST_IDLE) ||
                                ((r_state == ST_HOLD) && out_ready));
    assign w_gen    = (r_state == ST_GEN);
    assign w_done   = w_gen && (r_cnt == CNT_W'(CHIPS - 1));
    assign w_wrap   = w_gen && (r_phase == LAST_PHASE);
    assign w_load   = (w_accept && restart) || w_wrap;

    assign epoch_cnt = r_epoch;
    assign sv_err    = r_sv_err;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            gps_ca_lfsr u_lfsr (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (w_load),
                .advance (w_gen),
                .sv      (r_sv[6*c +: 6]),
                .chip    (w_chip[c])
            );
            assign w_sv_err_new[c] = !sv_valid(sv_num[6*c +: 6]);
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_GEN;
            ST_GEN:  if (w_done)   w_next = ST_HOLD;
            ST_HOLD: begin
                if (w_accept)       w_next = ST_GEN;
                else if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (r_state == ST_GEN);
        out_valid = (r_state == ST_HOLD);
    end

    // Latched SVs, shared code phase, epoch count and in-word chip counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sv         <= '0;
            r_sv_err     <= '0;
            r_phase      <= '0;
            r_word_phase <= '0;
            r_epoch      <= '0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (restart) begin
                r_sv         <= sv_num;
                r_sv_err     <= w_sv_err_new;
                r_phase      <= '0;
                r_word_phase <= '0;
                r_epoch      <= '0;
            end else begin
                r_word_phase <= r_phase;
            end
        end else if (w_gen) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_wrap) begin
                r_phase <= '0;
                r_epoch <= r_epoch + 1'b1;
            end else begin
                r_phase <= r_phase + 10'd1;
            end
        end
    end

    // Drop each channel's chip into its slot; earliest chip lands in the MSB
    always_comb begin
        w_word_next = r_word;
        for (int c = 0; c < NUM_CH; c++) begin
            w_word_next[CHIPS*c + CHIPS - 1 - int'(r_cnt)] = w_chip[c];
        end
    end

    // Word assembly; outputs update only when the word is complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word   <= '0;
            ca_code  <= '0;
            chip_idx <= '0;
        end else if (w_gen) begin
            r_word <= w_word_next;
            if (w_done) begin
                ca_code  <= w_word_next;
                chip_idx <= r_word_phase;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gps_ca_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gps_ca_multi
//  Description : Self-checking bench for gps_ca_multi (NUM_CH=4, CHIPS=10)
//                with a golden Gold-code model feeding a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gps_ca_multi;

    localparam int NUM_CH  = 4;
    localparam int CHIPS   = 10;
    localparam int EPOCH_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    restart = 1'b0;
    logic                    out_ready = 1'b1;
    logic [6*NUM_CH-1:0]     sv_num = '0;
    logic                    busy;
    logic                    out_valid;
    logic [CHIPS*NUM_CH-1:0] ca_code;
    logic [9:0]              chip_idx;
    logic [EPOCH_W-1:0]      epoch_cnt;
    logic [NUM_CH-1:0]       sv_err;

    always #5 clk = ~clk;

    gps_ca_multi #(.NUM_CH(NUM_CH), .CHIPS(CHIPS), .EPOCH_W(EPOCH_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .restart   (restart),
        .sv_num    (sv_num),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ca_code   (ca_code),
        .chip_idx  (chip_idx),
        .epoch_cnt (epoch_cnt),
        .sv_err    (sv_err)
    );

    typedef struct {
        logic [CHIPS*NUM_CH-1:0] code;
        logic [9:0]              idx;
        logic [EPOCH_W-1:0]      ep;
        logic [NUM_CH-1:0]       err;
    } exp_t;

    exp_t               q[$];
    exp_t               r_pop;
    bit                 seq [0:63][0:1022];
    logic [5:0]         m_sv [NUM_CH];
    int                 m_phase = 0;
    logic [EPOCH_W-1:0] m_epoch = '0;
    int                 n_total = 0;
    int                 n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden C/A sequence for one SV, stages indexed 1..10 as in the ICD
    task automatic build(input int sv);
        bit g1 [1:10];
        bit g2 [1:10];
        bit f1, f2;
        int a, b;
        case (sv)
            1:  begin a = 2; b = 6;  end
            2:  begin a = 3; b = 7;  end
            5:  begin a = 1; b = 9;  end
            37: begin a = 4; b = 10; end
            default: begin a = 1; b = 1; end
        endcase
        for (int i = 1; i <= 10; i++) begin g1[i] = 1'b1; g2[i] = 1'b1; end
        for (int n = 0; n < 1023; n++) begin
            seq[sv][n] = g1[10] ^ g2[a] ^ g2[b];
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            for (int i = 10; i >= 2; i--) begin g1[i] = g1[i-1]; g2[i] = g2[i-1]; end
            g1[1] = f1;
            g2[1] = f2;
        end
    endtask

    function automatic logic [23:0] pack4(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    // Advance the model by one word and queue the expected result
    task automatic push_word(input bit rs, input logic [23:0] svs);
        exp_t e;
        int   ph;
        bit   ok;
        if (rs) begin
            for (int c = 0; c < NUM_CH; c++) m_sv[c] = svs[6*c +: 6];
            m_phase = 0;
            m_epoch = '0;
        end
        e.code = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ok = (m_sv[c] != 6'd0) && (m_sv[c] <= 6'd37);
            e.err[c] = !ok;
            for (int k = 0; k < CHIPS; k++) begin
                ph = (m_phase + k) % 1023;
                e.code[CHIPS*c + CHIPS-1-k] = ok ? seq[m_sv[c]][ph] : 1'b0;
            end
        end
        e.idx = 10'(m_phase);
        if (m_phase + CHIPS >= 1023) m_epoch = m_epoch + 1'b1;
        m_phase = (m_phase + CHIPS) % 1023;
        e.ep = m_epoch;
        q.push_back(e);
    endtask

    task automatic drive_start(input bit rs, input logic [23:0] svs);
        int n = 0;
        while ((busy || (out_valid && !out_ready)) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk_eq("accept_timeout", 64'(n), 0);
        start = 1'b1; restart = rs; sv_num = svs;
        push_word(rs, svs);
        @(posedge clk); #1;
        start = 1'b0; restart = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        chk_eq("busy_gen", 64'(busy), 1);
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk_eq("latency", 64'(n), CHIPS);
    endtask

    task automatic issue(input bit rs, input logic [23:0] svs);
        drive_start(rs, svs);
        wait_valid();
    endtask

    // Scoreboard: compare whenever a word is handed over
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk_eq("sb_unexpected", 1, 0);
            end else begin
                r_pop = q.pop_front();
                chk_eq("sb_code",  64'(ca_code),   64'(r_pop.code));
                chk_eq("sb_idx",   64'(chip_idx),  64'(r_pop.idx));
                chk_eq("sb_epoch", 64'(epoch_cnt), 64'(r_pop.ep));
                chk_eq("sb_err",   64'(sv_err),    64'(r_pop.err));
            end
        end
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) m_sv[c] = '0;
        build(1); build(2); build(5); build(37);

        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy",  64'(busy), 0);
        chk_eq("rst_valid", 64'(out_valid), 0);
        chk_eq("rst_code",  64'(ca_code), 0);
        chk_eq("rst_idx",   64'(chip_idx), 0);
        chk_eq("rst_epoch", 64'(epoch_cnt), 0);
        chk_eq("rst_err",   64'(sv_err), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First word after restart, anchored to known SV1/SV2 prefixes
        issue(1'b1, pack4(1, 2, 5, 37));
        chk_eq("w0_ch0", 64'(ca_code[9:0]),   64'(10'o1440));
        chk_eq("w0_ch1", 64'(ca_code[19:10]), 64'(10'o1620));
        chk_eq("w0_idx", 64'(chip_idx), 0);

        // Continuation without restart; sv_num must be ignored
        issue(1'b0, pack4(9, 9, 9, 9));
        chk_eq("w1_idx", 64'(chip_idx), 10);

        // Back-to-back words up to the one straddling the epoch wrap
        for (int w = 2; w <= 102; w++) issue(1'b0, 24'($urandom));
        chk_eq("wrap_idx",   64'(chip_idx), 1020);
        chk_eq("wrap_tail",  64'(ca_code[6:0]), 64'(7'b1100100));
        chk_eq("wrap_epoch", 64'(epoch_cnt), 1);
        @(posedge clk); #1;

        // Back-pressure: word held, stray start ignored
        out_ready = 1'b0;
        issue(1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            start   = (i == 5);
            restart = (i == 5);
            sv_num  = pack4(2, 1, 37, 5);
            @(posedge clk); #1;
            chk_eq("hold_code",  64'(ca_code), 64'(q[0].code));
            chk_eq("hold_busy",  64'(busy), 0);
            chk_eq("hold_valid", 64'(out_valid), 1);
        end
        start = 1'b0; restart = 1'b0;
        out_ready = 1'b1;
        drive_start(1'b0, '0);
        wait_valid();
        @(posedge clk); #1;

        // Invalid SVs on channels 2 and 3
        issue(1'b1, pack4(1, 2, 0, 40));
        chk_eq("err_flags", 64'(sv_err), 64'(4'b1100));
        chk_eq("err_zero",  64'(ca_code[39:20]), 0);
        @(posedge clk); #1;

        // Reset in the middle of generation
        drive_start(1'b1, pack4(1, 2, 5, 37));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_busy",  64'(busy), 0);
        chk_eq("mid_valid", 64'(out_valid), 0);
        chk_eq("mid_code",  64'(ca_code), 0);
        chk_eq("mid_idx",   64'(chip_idx), 0);
        chk_eq("mid_epoch", 64'(epoch_cnt), 0);
        chk_eq("mid_err",   64'(sv_err), 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, pack4(1, 2, 5, 37));
        chk_eq("re_ch0", 64'(ca_code[9:0]),   64'(10'o1440));
        chk_eq("re_ch1", 64'(ca_code[19:10]), 64'(10'o1620));
        chk_eq("re_idx", 64'(chip_idx), 0);
        @(posedge clk); #1;
        chk_eq("sb_drained", 64'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
